// File: rtl/ysyx_23060124_rf_scoreboard_pkg.sv
// Shared definitions for the register-file scoreboard.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents:
//   REG_NUM, REG_ADDR_W : GPR file geometry
//   sb_act_e            : per-counter action decoded from inc/dec
//   cnt_max_of()        : saturation value of a CNT_W-bit counter
//   sb_act()            : folds inc/dec into a single action
package ysyx_23060124_rf_scoreboard_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    SB_HOLD = 2'd0,
    SB_INC  = 2'd1,
    SB_DEC  = 2'd2
  } sb_act_e;

  // Largest value a counter of width w can hold; counters saturate here.
  function automatic int unsigned cnt_max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // An issue and a retire to the same register in the same cycle cancel.
  function automatic sb_act_e sb_act(input logic inc, input logic dec);
    sb_act_e act;
    act = SB_HOLD;
    if (inc && !dec) act = SB_INC;
    else if (dec && !inc) act = SB_DEC;
    return act;
  endfunction

endpackage

// File: rtl/ysyx_23060124_sb_cnt.sv
// Single saturating up/down in-flight counter for one GPR.
// Latency: count updates on the clock edge after inc/dec; o_err is same-cycle.
// Backpressure: none; illegal overflow/underflow requests are dropped and flagged.
//
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   i_inc        : an instruction writing this register was issued
//   i_dec        : an instruction writing this register retired
//   o_cnt        : current number of in-flight writes
//   o_err        : this cycle's request would overflow or underflow (pulse)
module ysyx_23060124_sb_cnt
  import ysyx_23060124_rf_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max_of(CNT_W));

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err;
  sb_act_e          w_act;

  assign w_act = sb_act(i_inc, i_dec);

  // Saturate rather than wrap: a wrapped count would silently free a
  // register that still has writes in flight.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err     = 1'b0;
    case (w_act)
      SB_INC: begin
        if (r_cnt == CNT_MAX) w_err = 1'b1;
        else                  w_cnt_nxt = r_cnt + 1'b1;
      end
      SB_DEC: begin
        if (r_cnt == '0) w_err = 1'b1;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      default: begin
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  assign o_cnt = r_cnt;
  assign o_err = w_err;

endmodule

// File: rtl/ysyx_23060124_rf_scoreboard.sv
// Register-file scoreboard: tracks in-flight GPR writes and qualifies decode.
// Latency: counters update 1 cycle after issue/writeback; o_rf_valid is
//          combinational from registered counts and the decode fields only.
// Backpressure: o_rf_valid low stalls the ID/EX handshake; never depends on
//          i_issue or i_wb_*, so no loop with the ID/EX ready path.
//
// Ports:
//   clock, reset              : clock, asynchronous active-high reset
//   i_issue/_wen/_rd          : ID->EX handshake fire and its destination
//   i_rs1/_rs2, i_rs*_used    : sources of the instruction in decode
//   i_dec_rd, i_dec_wen       : destination of the instruction in decode
//   i_wb_valid/_wen/_rd       : WBU retirement and its destination
//   o_rf_valid                : decode may proceed
//   o_busy[31:0]              : per-register "write in flight" (bit 0 is 0)
//   o_idle                    : no writes in flight anywhere
//   o_err                     : sticky overflow/underflow flag
module ysyx_23060124_rf_scoreboard
  import ysyx_23060124_rf_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_issue,
  input  logic                  i_issue_wen,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_dec_rd,
  input  logic                  i_dec_wen,
  input  logic                  i_wb_valid,
  input  logic                  i_wb_wen,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  output logic                  o_rf_valid,
  output logic [REG_NUM-1:0]    o_busy,
  output logic                  o_idle,
  output logic                  o_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max_of(CNT_W));

  logic [REG_NUM-1:0] w_inc;
  logic [REG_NUM-1:0] w_dec;
  logic [REG_NUM-1:0] w_busy;
  logic [REG_NUM-1:0] w_full;
  logic [REG_NUM-1:0] w_cnt_err;
  logic               w_rs1_stall;
  logic               w_rs2_stall;
  logic               w_rd_stall;
  logic               r_err;

  // x0 is hardwired zero: it never gets a counter and never stalls.
  assign w_inc[0]     = 1'b0;
  assign w_dec[0]     = 1'b0;
  assign w_busy[0]    = 1'b0;
  assign w_full[0]    = 1'b0;
  assign w_cnt_err[0] = 1'b0;

  for (genvar n = 1; n < REG_NUM; n++) begin : g_cnt
    logic [CNT_W-1:0] w_cnt;

    assign w_inc[n] = i_issue    && i_issue_wen && (i_issue_rd == REG_ADDR_W'(n));
    assign w_dec[n] = i_wb_valid && i_wb_wen    && (i_wb_rd    == REG_ADDR_W'(n));

    ysyx_23060124_sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .i_inc (w_inc[n]),
      .i_dec (w_dec[n]),
      .o_cnt (w_cnt),
      .o_err (w_cnt_err[n])
    );

    assign w_busy[n] = |w_cnt;
    assign w_full[n] = (w_cnt == CNT_MAX);
  end

  // No writeback bypass: a retiring register is only seen free once its
  // counter has actually dropped, which lines up with the RF write edge.
  assign w_rs1_stall = i_rs1_used && w_busy[i_rs1];
  assign w_rs2_stall = i_rs2_used && w_busy[i_rs2];
  // A saturated destination counter cannot absorb another issue.
  assign w_rd_stall  = i_dec_wen  && w_full[i_dec_rd];

  assign o_rf_valid = !w_rs1_stall && !w_rs2_stall && !w_rd_stall;
  assign o_busy     = w_busy;
  assign o_idle     = ~|w_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_err <= 1'b0;
    else if (|w_cnt_err) r_err <= 1'b1;
  end

  assign o_err = r_err;

endmodule

// File: tb/tb_ysyx_23060124_rf_scoreboard.sv
module tb_ysyx_23060124_rf_scoreboard;

  logic        clock;
  logic        reset;
  logic        i_issue;
  logic        i_issue_wen;
  logic [4:0]  i_issue_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic        i_rs1_used;
  logic        i_rs2_used;
  logic [4:0]  i_dec_rd;
  logic        i_dec_wen;
  logic        i_wb_valid;
  logic        i_wb_wen;
  logic [4:0]  i_wb_rd;
  logic        o_rf_valid;
  logic [31:0] o_busy;
  logic        o_idle;
  logic        o_err;

  ysyx_23060124_rf_scoreboard #(.CNT_W(2)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .i_issue     (i_issue),
    .i_issue_wen (i_issue_wen),
    .i_issue_rd  (i_issue_rd),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_rs1_used  (i_rs1_used),
    .i_rs2_used  (i_rs2_used),
    .i_dec_rd    (i_dec_rd),
    .i_dec_wen   (i_dec_wen),
    .i_wb_valid  (i_wb_valid),
    .i_wb_wen    (i_wb_wen),
    .i_wb_rd     (i_wb_rd),
    .o_rf_valid  (o_rf_valid),
    .o_busy      (o_busy),
    .o_idle      (o_idle),
    .o_err       (o_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] busy;
    logic        idle;
    logic        err;
    logic        rfv;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  int n_vec;
  int n_miss;

  // Reference model: counters saturate at 3 (CNT_W = 2).
  int   m_cnt[32];
  logic m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy_bit(input logic [4:0] r);
    return (r != 5'd0) && (m_cnt[r] != 0);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int n = 1; n < 32; n++) b[n] = (m_cnt[n] != 0);
    return b;
  endfunction

  function automatic logic m_rfv();
    return !(i_rs1_used && m_busy_bit(i_rs1)) &&
           !(i_rs2_used && m_busy_bit(i_rs2)) &&
           !(i_dec_wen && (i_dec_rd != 5'd0) && (m_cnt[i_dec_rd] == 3));
  endfunction

  task automatic set_dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] drd, input logic dwen);
    i_rs1 = rs1; i_rs1_used = u1; i_rs2 = rs2; i_rs2_used = u2;
    i_dec_rd = drd; i_dec_wen = dwen;
  endtask

  // One clock: drive at negedge, check the pre-edge qualifier, predict the
  // post-edge state into the scoreboard, then compare after the edge.
  task automatic step(input logic iss, input logic iwen, input logic [4:0] ird,
                      input logic wbv, input logic wwen, input logic [4:0] wrd,
                      input string tag);
    exp_t e;
    exp_t g;
    logic inc;
    logic dec;
    @(negedge clock);
    i_issue = iss; i_issue_wen = iwen; i_issue_rd = ird;
    i_wb_valid = wbv; i_wb_wen = wwen; i_wb_rd = wrd;
    #1;
    chk({tag, "_pre_rfv"}, 32'(o_rf_valid), 32'(m_rfv()));
    for (int n = 1; n < 32; n++) begin
      inc = iss && iwen && (ird == 5'(n));
      dec = wbv && wwen && (wrd == 5'(n));
      if (inc && !dec) begin
        if (m_cnt[n] == 3) m_err = 1'b1;
        else               m_cnt[n]++;
      end else if (dec && !inc) begin
        if (m_cnt[n] == 0) m_err = 1'b1;
        else               m_cnt[n]--;
      end
    end
    e.busy = m_busy();
    e.idle = (e.busy == 32'd0);
    e.err  = m_err;
    e.rfv  = m_rfv();
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    g = sb_q.pop_front();
    chk({g.tag, "_busy"}, o_busy, g.busy);
    chk({g.tag, "_idle"}, 32'(o_idle), 32'(g.idle));
    chk({g.tag, "_err"},  32'(o_err),  32'(g.err));
    chk({g.tag, "_rfv"},  32'(o_rf_valid), 32'(g.rfv));
    i_issue = 1'b0; i_issue_wen = 1'b0; i_wb_valid = 1'b0; i_wb_wen = 1'b0;
  endtask

  task automatic model_reset();
    for (int n = 0; n < 32; n++) m_cnt[n] = 0;
    m_err = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    model_reset();
    reset = 1'b1;
    i_issue = 1'b0; i_issue_wen = 1'b0; i_issue_rd = 5'd0;
    i_wb_valid = 1'b0; i_wb_wen = 1'b0; i_wb_rd = 5'd0;
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

    // 1: reset state
    #3;
    chk("rst_busy", o_busy, 32'd0);
    chk("rst_idle", 32'(o_idle), 32'd1);
    chk("rst_rfv",  32'(o_rf_valid), 32'd1);
    chk("rst_err",  32'(o_err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, "idle");

    // 2: RAW on x5, freed only the cycle after writeback
    set_dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1, 1, 5, 0, 0, 0, "raw_iss5");
    step(0, 0, 0, 0, 0, 0, "raw_hold5");
    step(0, 0, 0, 1, 1, 5, "raw_wb5");
    // issue without wen must not mark anything busy
    step(1, 0, 5, 0, 0, 0, "iss_nowen");

    // 4: same-cycle issue and writeback net to zero
    set_dec(5'd9, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    step(1, 1, 9, 0, 0, 0, "same_iss9");
    step(1, 1, 9, 1, 1, 9, "same_cnt1");
    step(0, 0, 0, 1, 1, 9, "same_wb9");
    step(1, 1, 9, 1, 1, 9, "same_cnt0");

    // 5: x0 never tracked, then an underflow
    set_dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    step(1, 1, 0, 0, 0, 0, "x0_iss");
    step(0, 0, 0, 1, 1, 0, "x0_wb");
    step(0, 0, 0, 1, 1, 3, "uflow3");

    // 3: saturation on x7
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    step(1, 1, 7, 0, 0, 0, "sat_i1");
    step(1, 1, 7, 0, 0, 0, "sat_i2");
    step(1, 1, 7, 0, 0, 0, "sat_i3");
    step(1, 1, 7, 0, 0, 0, "sat_i4");
    set_dec(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step(0, 0, 0, 1, 1, 7, "sat_w1");
    step(0, 0, 0, 1, 1, 7, "sat_w2");
    step(0, 0, 0, 1, 1, 7, "sat_w3");

    // mixed traffic over a few registers
    for (int k = 0; k < 40; k++) begin
      set_dec(5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
           "mix");
    end

    // 6: asynchronous reset between edges
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
    step(1, 1, 1, 0, 0, 0, "pre_rst1");
    step(1, 1, 2, 0, 0, 0, "pre_rst2");
    step(1, 1, 3, 0, 0, 0, "pre_rst3");
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", o_busy, 32'd0);
    chk("arst_idle", 32'(o_idle), 32'd1);
    chk("arst_rfv",  32'(o_rf_valid), 32'd1);
    chk("arst_err",  32'(o_err), 32'd0);
    #1;
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_rf_scoreboard.md
# ysyx_23060124_rf_scoreboard

Register-file scoreboard that produces the `rf_valid` qualifier consumed by the ID/EX pipeline register. It tracks in-flight writes to every GPR.
- Issue side: counts up on each ID→EX handshake that carries a register write.
- Writeback side: counts down when WBU retires that write.
- `o_rf_valid` is deasserted while any source operand of the decoding instruction, or its destination counter, is not safe.

It sits beside the IDU and is the producer of the operand-ready condition that the ID/EX stage only samples.

## Interface

Parameters:
- `CNT_W`, default 2: width of each per-register in-flight counter; maximum count is 2^CNT_W−1.

Ports (all single-bit unless noted):
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `i_issue`, input, 1: ID→EX handshake fire (`pre_valid && pre_ready` of the ID/EX register).
- `i_issue_wen`, input, 1: the issued instruction writes a GPR.
- `i_issue_rd`, input, 5: destination of the issued instruction.
- `i_rs1`, input, 5: source 1 of the instruction currently in decode.
- `i_rs2`, input, 5: source 2 of the instruction currently in decode.
- `i_rs1_used`, input, 1: decode instruction reads rs1.
- `i_rs2_used`, input, 1: decode instruction reads rs2.
- `i_dec_rd`, input, 5: destination of the instruction currently in decode.
- `i_dec_wen`, input, 1: decode instruction writes `i_dec_rd`.
- `i_wb_valid`, input, 1: WBU retires an instruction this cycle.
- `i_wb_wen`, input, 1: the retiring instruction writes a GPR.
- `i_wb_rd`, input, 5: destination being written back.
- `o_rf_valid`, output, 1: decode operands are safe and the destination counter is not saturated.
- `o_busy`, output, 32: bit n = counter n nonzero; bit 0 is always 0.
- `o_idle`, output, 1: all counters are zero. Used by fence_i, ecall and mret to drain the pipeline.
- `o_err`, output, 1: sticky protocol error flag.

## Operation

- State: 31 counters `cnt[1..31]`, each CNT_W bits; x0 has no counter and is never busy. Plus the `o_err` flop.
- Increment condition: `inc[n] = i_issue && i_issue_wen && i_issue_rd==n && n!=0`.
- Decrement condition: `dec[n] = i_wb_valid && i_wb_wen && i_wb_rd==n && n!=0`.
- Per-register update:
  - `inc` only: cnt+1.
  - `dec` only: cnt−1.
  - Both, or neither: hold. Simultaneous issue and writeback to the same rd nets zero.
- Saturation: `inc` only with cnt == max → hold and set `o_err`. No wrap-around.
- Underflow: `dec` only with cnt == 0 → hold at 0 and set `o_err`.
- `o_err` clears only on reset.
- `o_rf_valid` is combinational from registered counters only:
  - It is the AND of `!(i_rs1_used && busy[i_rs1])`, `!(i_rs2_used && busy[i_rs2])` and `!(i_dec_wen && cnt[i_dec_rd]==max)`.
- No writeback bypass: a register retiring in cycle t becomes readable in cycle t+1, which matches the register-file write edge.
- Sources equal to x0 never stall.
- `o_idle` is the NOR of all `o_busy` bits.

## Timing

- Reset (asynchronous, immediate): all counters 0, `o_err` 0. Therefore:
  - `o_busy` = 0.
  - `o_idle` = 1.
  - `o_rf_valid` = 1.
- Reset asserted mid-operation discards all in-flight counts in the same instant, without waiting for a clock edge.
- Counter update latency is 1 cycle.
  - Issue at edge t → `o_busy[rd]` = 1 and `o_rf_valid` low for a dependent instruction from t+1.
  - Writeback at edge t → bit clears from t+1.
- `o_rf_valid` has zero-cycle combinational dependence on `i_rs*`, `i_*_used` and `i_dec_*`.
  - It has no combinational path from `i_issue` or `i_wb_*`, so no loop is formed with the ID/EX `pre_ready`.
- Back-to-back writes to the same rd count independently. The register becomes free only after the last of them retires.

## Structure

- Shared package:
  - `REG_NUM` = 32.
  - `REG_ADDR_W` = 5.
  - Localparam `CNT_MAX` derived from CNT_W.
- One natural sub-module: `ysyx_23060124_sb_cnt`, a single saturating up/down counter with inc, dec and error output, instantiated 31 times via a generate loop.
- Top level: decoders, busy/idle reduction, `o_rf_valid` logic, and `o_err` as the OR-sticky of the counter error outputs.

## Test plan

1. Reset, then all inputs idle → `o_busy`=0, `o_idle`=1, `o_rf_valid`=1, `o_err`=0.
2. Issue wen rd=5, then decode rs1=5 used → `o_rf_valid`=0 from next cycle. Writeback rd=5 → `o_rf_valid`=1 the cycle after writeback, not the same cycle.
3. Three issues to rd=7 (CNT_W=2) → cnt=3.
   - Decode `i_dec_rd`=7 wen → `o_rf_valid`=0.
   - A 4th forced issue → `o_err`=1 and cnt stays 3.
   - Three writebacks → bit 7 clears only after the third.
4. Same-cycle issue rd=9 and writeback rd=9 with cnt=1 → cnt stays 1 and `o_busy[9]`=1. Same case with cnt=0 → stays 0 and no error.
5. Issue or writeback rd=0, and decode rs1=rs2=0 → `o_busy`=0, `o_rf_valid`=1, `o_err`=0. Writeback rd=3 with cnt=0 → `o_err`=1, `o_busy[3]`=0.
6. Issues to rd=1, 2, 3 outstanding, then reset asserted between edges → `o_busy`=0 and `o_idle`=1 immediately.
